// File: rtl/score_pkg.sv
// Shared types and constants for the score recorder.
package score_pkg;

  localparam int unsigned SLOTS  = 160;
  localparam int unsigned NOTE_W = 6;
  localparam int unsigned SLOT_W = 8;

  localparam logic [NOTE_W-1:0] REST_CODE = 6'b000000;

  typedef logic [NOTE_W-1:0] note_t;
  typedef logic [SLOT_W-1:0] slot_idx_t;

  typedef enum logic [1:0] {
    StIdle,
    StCountIn,
    StRecord
  } score_state_t;

  // Bit 5 clear means "rest"; any rest code collapses to REST_CODE so all rests vote together.
  function automatic note_t normalise(input note_t n);
    return n[NOTE_W-1] ? n : REST_CODE;
  endfunction

endpackage

// File: rtl/majority_vote.sv
// Boyer-Moore majority voter over one eighth-note window.
module majority_vote
  import score_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear,
  input  logic  valid,
  input  note_t sample,
  output note_t candidate,
  output logic  nonzero
);

  note_t             cand_q;
  logic [CNT_W-1:0]  count_q;

  // Candidate/count update; a sample arriving with clear seeds the fresh window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_q  <= REST_CODE;
      count_q <= '0;
    end else if (clear) begin
      if (valid) begin
        cand_q  <= sample;
        count_q <= CNT_W'(1);
      end else begin
        cand_q  <= REST_CODE;
        count_q <= '0;
      end
    end else if (valid) begin
      if (count_q == '0) begin
        cand_q  <= sample;
        count_q <= CNT_W'(1);
      end else if (sample == cand_q) begin
        if (count_q != '1) begin
          count_q <= count_q + CNT_W'(1);
        end
      end else begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign candidate = cand_q;
  assign nonzero   = (count_q != '0);

endmodule

// File: rtl/score_recorder.sv
// Eighth-note tick generator, start/stop FSM with count-in, and slot register file.
module score_recorder
  import score_pkg::*;
#(
  parameter int unsigned EIGHTH_CYCLES = 18_562_500,
  parameter int unsigned COUNTIN_TICKS = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          start_in,
  input  logic                          stop_in,
  input  logic                          note_valid_in,
  input  logic [NOTE_W-1:0]             note_in,
  output logic [SLOTS-1:0][NOTE_W-1:0]  notes_out,
  output logic [SLOT_W-1:0]             slot_idx_out,
  output logic                          recording_out,
  output logic                          counting_in_out,
  output logic                          tick_out,
  output logic                          done_out
);

  localparam int unsigned CYC_W = $clog2(EIGHTH_CYCLES);
  localparam int unsigned CNT_W = $clog2(EIGHTH_CYCLES + 1);
  localparam int unsigned CI_W  = (COUNTIN_TICKS > 1) ? $clog2(COUNTIN_TICKS) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(EIGHTH_CYCLES - 1);
  localparam logic [CI_W-1:0]  CI_LAST   = CI_W'(COUNTIN_TICKS - 1);
  localparam slot_idx_t        SLOT_LAST = slot_idx_t'(SLOTS - 1);

  score_state_t                 state_q;
  logic [CYC_W-1:0]             cyc_q;
  logic [CI_W-1:0]              ci_q;
  slot_idx_t                    slot_q;
  logic [SLOTS-1:0][NOTE_W-1:0] notes_q;
  logic                         rec_q;
  logic                         cnt_q;
  logic                         tick_q;
  logic                         done_q;

  logic  tick;
  logic  vote_clear;
  logic  vote_valid;
  note_t vote_cand;
  logic  vote_nonzero;

  assign tick       = (state_q != StIdle) && (cyc_q == CYC_LAST);
  // The window restarts on every tick; outside RECORD the voter is held empty.
  assign vote_clear = (state_q != StRecord) || tick;
  assign vote_valid = note_valid_in && (state_q == StRecord);

  majority_vote #(
    .CNT_W (CNT_W)
  ) u_vote (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .clear     (vote_clear),
    .valid     (vote_valid),
    .sample    (normalise(note_in)),
    .candidate (vote_cand),
    .nonzero   (vote_nonzero)
  );

  // Start/stop FSM, tick counter, slot commit and registered status outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      ci_q    <= '0;
      slot_q  <= '0;
      notes_q <= '0;
      rec_q   <= 1'b0;
      cnt_q   <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_in && !stop_in) begin
            notes_q <= '0;
            cyc_q   <= '0;
            ci_q    <= '0;
            slot_q  <= '0;
            cnt_q   <= 1'b1;
            state_q <= StCountIn;
          end
        end
        StCountIn: begin
          if (stop_in) begin
            cnt_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            cyc_q <= tick ? '0 : cyc_q + CYC_W'(1);
            if (tick) begin
              tick_q <= 1'b1;
              if (ci_q == CI_LAST) begin
                ci_q    <= '0;
                cnt_q   <= 1'b0;
                rec_q   <= 1'b1;
                state_q <= StRecord;
              end else begin
                ci_q <= ci_q + CI_W'(1);
              end
            end
          end
        end
        StRecord: begin
          if (stop_in) begin
            // Partial window is dropped; the current slot keeps its cleared value.
            rec_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            cyc_q <= tick ? '0 : cyc_q + CYC_W'(1);
            if (tick) begin
              tick_q          <= 1'b1;
              notes_q[slot_q] <= vote_nonzero ? vote_cand : REST_CODE;
              if (slot_q == SLOT_LAST) begin
                rec_q   <= 1'b0;
                done_q  <= 1'b1;
                state_q <= StIdle;
              end else begin
                slot_q <= slot_q + slot_idx_t'(1);
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign notes_out       = notes_q;
  assign slot_idx_out    = slot_q;
  assign recording_out   = rec_q;
  assign counting_in_out = cnt_q;
  assign tick_out        = tick_q;
  assign done_out        = done_q;

endmodule

// File: tb/tb_score_recorder.sv
// Self-checking bench for score_recorder with a window-based reference model.
module tb_score_recorder;
  import score_pkg::*;

  localparam int E    = 8;
  localparam int CI   = 8;
  localparam int REC0 = CI * E;              // first RECORD cycle, counted from t0+1
  localparam int FULL = (CI + SLOTS) * E;    // done cycle of a full take
  localparam int NCYC = FULL + 1;
  localparam logic [5:0] A = 6'b100111;
  localparam logic [5:0] B = 6'b101001;

  logic                    clk = 1'b0;
  logic                    rst_n, start, stop, valid;
  logic [5:0]              note;
  logic [SLOTS-1:0][5:0]   notes_w;
  logic [7:0]              slot_w;
  logic                    rec, cin, tick, done;

  always #5 clk = ~clk;

  score_recorder #(
    .EIGHTH_CYCLES (E),
    .COUNTIN_TICKS (CI)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .start_in        (start),
    .stop_in         (stop),
    .note_valid_in   (valid),
    .note_in         (note),
    .notes_out       (notes_w),
    .slot_idx_out    (slot_w),
    .recording_out   (rec),
    .counting_in_out (cin),
    .tick_out        (tick),
    .done_out        (done)
  );

  int         checks = 0;
  int         errors = 0;
  logic       sv [NCYC];
  logic [5:0] sn [NCYC];
  logic [5:0] exp_notes [SLOTS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Boyer-Moore result over the valid samples in cycles lo..hi.
  function automatic logic [5:0] bm(input int lo, input int hi);
    logic [5:0] cand;
    logic [5:0] n;
    int         cnt;
    int         cmax;
    cand = 6'b0;
    cnt  = 0;
    cmax = (1 << $clog2(E + 1)) - 1;
    for (int c = lo; c <= hi; c++) begin
      if (sv[c]) begin
        n = sn[c][5] ? sn[c] : 6'b0;
        if (cnt == 0) begin
          cand = n;
          cnt  = 1;
        end else if (n == cand) begin
          if (cnt < cmax) cnt++;
        end else begin
          cnt--;
        end
      end
    end
    return (cnt != 0) ? cand : 6'b0;
  endfunction

  // Slot s is committed at the tick in cycle REC0+(s+1)E-1 if the take is still alive then.
  function automatic void build_expected(input int end_c);
    int tc, lo;
    for (int s = 0; s < SLOTS; s++) begin
      tc = REC0 + (s + 1) * E - 1;
      lo = (s == 0) ? REC0 : REC0 + s * E - 1;
      exp_notes[s] = (tc < end_c) ? bm(lo, tc - 1) : 6'b0;
    end
  endfunction

  function automatic logic [5:0] pick();
    logic [5:0] r;
    r = 6'($urandom);
    case ($urandom % 4)
      0:       return A;
      1:       return B;
      2:       return {1'b1, r[4:0]};
      default: return {1'b0, r[4:0]};
    endcase
  endfunction

  task automatic put(input int s, input int idx, input logic [5:0] v);
    int base;
    base = ((s == 0) ? REC0 : REC0 + s * E - 1) + 1;
    sv[base + idx] = 1'b1;
    sn[base + idx] = v;
  endtask

  // mode 0: constant B; mode 1: directed windows then random; mode 2: random throughout.
  task automatic gen(input int mode);
    for (int c = 0; c < NCYC; c++) begin
      sv[c] = 1'b0;
      sn[c] = 6'($urandom);
      if (mode == 0) begin
        sv[c] = 1'b1;
        sn[c] = B;
      end else if (mode == 2 || c >= REC0 + 7 * E - 1) begin
        sv[c] = ($urandom % 4) != 0;
        sn[c] = pick();
      end
    end
    if (mode == 1) begin
      put(0, 0, A); put(0, 1, A); put(0, 2, B);
      put(1, 0, A); put(1, 1, B); put(1, 2, A); put(1, 3, B);
      put(2, 0, A); put(2, 1, B); put(2, 2, B);
      put(4, 0, 6'b011111);
      sv[REC0 + 6 * E - 1] = 1'b1;    // tick cycle of slot 5
      sn[REC0 + 6 * E - 1] = A;
    end
  endtask

  task automatic take(input int stop_c, input int restart_c, input int rst_c);
    int  fin, last, cc, exp_slot;
    bit  exp_tick;
    fin  = (stop_c >= 0) ? stop_c + 1 : FULL;
    last = (rst_c >= 0) ? rst_c + 1 : fin + 2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (rst_c >= 0 && c == rst_c + 1) begin
        rst_n = 1'b1;
        chk("rst_rec", 32'(rec), 32'(0));
        chk("rst_cin", 32'(cin), 32'(0));
        chk("rst_tick", 32'(tick), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_slot", 32'(slot_w), 32'(0));
        for (int s = 0; s < SLOTS; s++) chk($sformatf("rst_note[%0d]", s), 32'(notes_w[s]), 32'(0));
      end else begin
        cc       = (stop_c >= 0 && c > stop_c) ? stop_c : c;
        exp_slot = (cc < REC0) ? 0 : (((cc - REC0) / E > SLOTS - 1) ? SLOTS - 1 : (cc - REC0) / E);
        exp_tick = (c >= E) && (c % E == 0) && ((stop_c < 0) ? (c <= fin) : (c <= stop_c));
        chk($sformatf("cin@%0d", c), 32'(cin), 32'(c < REC0 && c < fin));
        chk($sformatf("rec@%0d", c), 32'(rec), 32'(c >= REC0 && c < fin));
        chk($sformatf("done@%0d", c), 32'(done), 32'(c == fin));
        chk($sformatf("tick@%0d", c), 32'(tick), 32'(exp_tick));
        chk($sformatf("slot@%0d", c), 32'(slot_w), 32'(exp_slot));
        if (exp_tick && c > REC0) begin
          chk($sformatf("commit[%0d]", (c - REC0) / E - 1), 32'(notes_w[(c - REC0) / E - 1]),
              32'(exp_notes[(c - REC0) / E - 1]));
        end
      end
      valid = (c < NCYC) ? sv[c] : 1'b0;
      note  = (c < NCYC) ? sn[c] : 6'b0;
      stop  = (c == stop_c);
      start = (c == restart_c);
      if (c == rst_c) rst_n = 1'b0;
    end
    valid = 1'b0;
    stop  = 1'b0;
    start = 1'b0;
    if (rst_c < 0) begin
      for (int s = 0; s < SLOTS; s++) chk($sformatf("final[%0d]", s), 32'(notes_w[s]), 32'(exp_notes[s]));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    valid = 1'b0;
    note  = 6'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rec", 32'(rec), 32'(0));
    chk("reset_cin", 32'(cin), 32'(0));
    chk("reset_tick", 32'(tick), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_slot", 32'(slot_w), 32'(0));
    for (int s = 0; s < SLOTS; s++) chk($sformatf("reset_note[%0d]", s), 32'(notes_w[s]), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full take with a constant pitched note.
    gen(0);
    build_expected(NCYC + 100);
    take(-1, -1, -1);
    for (int s = 0; s < SLOTS; s++) chk($sformatf("full_const[%0d]", s), 32'(notes_w[s]), 32'(B));

    // Directed voting windows, tick-cycle boundary, random tail, early stop mid slot 20.
    gen(1);
    build_expected(REC0 + 20 * E + 3);
    take(REC0 + 20 * E + 3, -1, -1);
    chk("vote_AAB", 32'(notes_w[0]), 32'(A));
    chk("vote_ABAB", 32'(notes_w[1]), 32'(0));
    chk("vote_ABB", 32'(notes_w[2]), 32'(B));
    chk("vote_none", 32'(notes_w[3]), 32'(0));
    chk("vote_rest", 32'(notes_w[4]), 32'(0));
    chk("boundary_cur", 32'(notes_w[5]), 32'(0));
    chk("boundary_next", 32'(notes_w[6]), 32'(A));
    chk("stop_slot20", 32'(notes_w[20]), 32'(0));

    // Simultaneous start+stop in IDLE must not start a take.
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("startstop_cin", 32'(cin), 32'(0));
    chk("startstop_rec", 32'(rec), 32'(0));
    chk("startstop_slot", 32'(slot_w), 32'(20));
    chk("startstop_note19", 32'(notes_w[19]), 32'(exp_notes[19]));

    // Random take: ignored start at slot 50, then reset shortly after.
    gen(2);
    build_expected(REC0 + 50 * E + 5);
    take(-1, REC0 + 50 * E + 2, REC0 + 50 * E + 5);
    @(posedge clk); #1;
    chk("post_rst_cin", 32'(cin), 32'(0));
    chk("post_rst_rec", 32'(rec), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
